// File: rtl/pingpong_wr_buffer.sv
// ---------------------------------------------------------------------------
// pingpong_wr_buffer
//
// Packs single-cycle write strobes from the capture stage into two
// alternating RAM banks (A = 0, B = 1). A completed bank is streamed to the
// consumer over valid/ready while the other bank fills. A write that arrives
// when the writer's bank is still full is dropped and flagged in a sticky
// overflow bit.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   wea, din   write strobe and data word from upstream
//   out_data   word presented to the consumer
//   out_valid  out_data/out_last valid
//   out_ready  consumer accepts when out_valid & out_ready
//   out_last   final word of a bank
//   bank_full  bit0 = bank A full, bit1 = bank B full
//   overflow   sticky: a write was dropped
//   clr_ovf    clears overflow (a drop in the same cycle wins)
//
// Read FSM
//   state    | meaning
//   RD_IDLE  | waiting for bank rd_bank to fill; issues read of addr 0
//   RD_FETCH | RAM output available; load it into out_data, raise out_valid
//   RD_VALID | word presented; hold until out_ready
// ---------------------------------------------------------------------------
module pingpong_wr_buffer #(
    parameter int int_bits  = 20,
    parameter int depth     = 256,
    parameter int addr_bits = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wea,
    input  logic [int_bits-1:0] din,
    output logic [int_bits-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [1:0]          bank_full,
    output logic                overflow,
    input  logic                clr_ovf
);

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_VALID = 2'd2
    } rd_state_t;

    localparam logic [addr_bits-1:0] last_addr = addr_bits'(depth - 1);
    localparam logic [addr_bits-1:0] addr_one  = addr_bits'(1);

    logic [int_bits-1:0]  mem_a [depth];
    logic [int_bits-1:0]  mem_b [depth];
    logic [int_bits-1:0]  q_a;
    logic [int_bits-1:0]  q_b;

    rd_state_t            rd_state;
    logic                 wr_bank;
    logic                 rd_bank;
    logic [addr_bits-1:0] wr_addr;
    logic [addr_bits-1:0] rd_addr;

    logic                 wr_ok;
    logic                 wr_drop;
    logic                 wr_wrap;
    logic                 rd_accept;
    logic                 rd_done;
    logic                 rd_en;
    logic [addr_bits-1:0] rd_raddr;
    logic [1:0]           full_nxt;

    // Full flags are taken from pre-edge values: a bank being freed this
    // cycle still blocks a write landing on it in the same cycle.
    assign wr_ok     = wea & ~bank_full[wr_bank];
    assign wr_drop   = wea &  bank_full[wr_bank];
    assign wr_wrap   = wr_ok & (wr_addr == last_addr);
    assign rd_accept = (rd_state == RD_VALID) & out_ready;
    assign rd_done   = rd_accept & (rd_addr == last_addr);
    assign rd_en     = ((rd_state == RD_IDLE) & bank_full[rd_bank]) |
                       (rd_accept & ~rd_done);
    assign rd_raddr  = (rd_state == RD_IDLE) ? '0 : rd_addr + addr_one;

    // The writer can never complete the bank the reader is freeing, so the
    // two updates always touch different bits.
    always_comb begin
        full_nxt = bank_full;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
        if (wr_wrap) full_nxt[wr_bank] = 1'b1;
    end

    // Plain synchronous RAMs, one per bank, so each maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok && !wr_bank) mem_a[wr_addr] <= din;
        if (wr_ok &&  wr_bank) mem_b[wr_addr] <= din;
        if (rd_en) begin
            q_a <= mem_a[rd_raddr];
            q_b <= mem_b[rd_raddr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            rd_bank   <= 1'b0;
            rd_addr   <= '0;
            rd_state  <= RD_IDLE;
            bank_full <= 2'b00;
            overflow  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (wr_ok) begin
                if (wr_wrap) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + addr_one;
                end
            end

            bank_full <= full_nxt;

            if (wr_drop)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;

            case (rd_state)
                RD_IDLE: begin
                    if (bank_full[rd_bank]) rd_state <= RD_FETCH;
                end
                RD_FETCH: begin
                    out_data  <= rd_bank ? q_b : q_a;
                    out_valid <= 1'b1;
                    out_last  <= (rd_addr == last_addr);
                    rd_state  <= RD_VALID;
                end
                RD_VALID: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (rd_addr == last_addr) begin
                            rd_bank  <= ~rd_bank;
                            rd_addr  <= '0;
                            rd_state <= RD_IDLE;
                        end else begin
                            rd_addr  <= rd_addr + addr_one;
                            rd_state <= RD_FETCH;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pingpong_wr_buffer.sv
// ---------------------------------------------------------------------------
// tb_pingpong_wr_buffer
//
// Bench for pingpong_wr_buffer at depth 4: a cycle table for one bank,
// directed multi-cycle sequences (reset, overflow, backpressure, concurrent
// fill/drain, reset mid-stream, set/clear collision) and a randomized run
// scored against a word-count / queue model.
// ---------------------------------------------------------------------------
module tb_pingpong_wr_buffer;
    localparam int W = 20;
    localparam int D = 4;
    localparam int A = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         wea;
    logic [W-1:0] din;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [1:0]   bank_full;
    logic         overflow;
    logic         clr_ovf;

    always #5 clk = ~clk;

    pingpong_wr_buffer #(.int_bits(W), .depth(D), .addr_bits(A)) dut (
        .clk       (clk),
        .reset     (reset),
        .wea       (wea),
        .din       (din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .bank_full (bank_full),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // handshake monitor: {last, data} of every accepted word, and which
    // full bit dropped at each end-of-bank handshake
    logic [W:0] got[$];
    logic [1:0] drained[$];
    logic [1:0] mon_pf;

    always @(posedge clk) begin
        if (reset && out_valid && out_ready) begin
            got.push_back({out_last, out_data});
            if (out_last) begin
                mon_pf = bank_full;
                #1;
                drained.push_back(mon_pf & ~bank_full);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; wea = 1'b0; din = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        got.delete();
        drained.delete();
    endtask

    task automatic wr(input logic [W-1:0] v);
        wea = 1'b1; din = v;
        cyc();
        wea = 1'b0;
        cyc();
    endtask

    task automatic wait_valid(input string nm, input int maxc);
        for (int i = 0; i < maxc && !out_valid; i++) cyc();
        chk(nm, out_valid, 1);
    endtask

    task automatic wait_got(input string nm, input int n, input int maxc);
        for (int i = 0; i < maxc && got.size() < n; i++) cyc();
        repeat (8) cyc();
        chk(nm, got.size(), n);
    endtask

    // stream must be first, first+1, ... with last on every D-th word
    task automatic check_stream(input string nm, input int first, input int n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk({nm, "_data"}, got[i][W-1:0], first + i);
            chk({nm, "_last"}, got[i][W], (i % D) == D - 1);
        end
    endtask

    typedef struct {
        logic         wea;
        logic [W-1:0] din;
        logic         rdy;
        logic         ev;
        logic [W-1:0] ed;
        logic         el;
        logic [1:0]   ef;
    } vec_t;

    vec_t tbl[17];

    // random-run model: counts of accepted and drained words
    int         n_in, n_out;
    logic [W-1:0] exp_q[$];
    logic       m_ovf;
    logic [1:0] m_full;
    logic       prev_wea, hs, set_ovf;
    int         fb;

    initial begin
        // single-bank table: row k drives inputs before edge k and lists the
        // outputs expected just after it
        for (int k = 0; k < 17; k++) begin
            tbl[k] = '{wea: 1'b0, din: '0, rdy: 1'b1, ev: 1'b0, ed: '0, el: 1'b0, ef: 2'b00};
            if (k <= 6 && k % 2 == 0) begin
                tbl[k].wea = 1'b1;
                tbl[k].din = W'(k / 2 + 1);
            end
            if (k >= 6 && k <= 14) tbl[k].ef = 2'b01;
            if (k >= 8 && k <= 14 && k % 2 == 0) begin
                tbl[k].ev = 1'b1;
                tbl[k].ed = W'((k - 8) / 2 + 1);
                tbl[k].el = (k == 14);
            end
        end

        // ---- reset held with wea toggling
        reset = 1'b0; wea = 1'b0; din = '0; out_ready = 1'b1; clr_ovf = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wea = ~wea;
            din = W'($urandom);
            cyc();
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_last", out_last, 0);
            chk("rst_full", bank_full, 0);
            chk("rst_ovf", overflow, 0);
        end
        wea = 1'b0;
        reset = 1'b1;
        cyc();
        chk("rel_full", bank_full, 0);
        chk("rel_valid", out_valid, 0);

        // ---- single bank, table driven
        do_reset();
        for (int k = 0; k < 17; k++) begin
            wea = tbl[k].wea; din = tbl[k].din; out_ready = tbl[k].rdy;
            cyc();
            chk("tbl_valid", out_valid, tbl[k].ev);
            chk("tbl_full", bank_full, tbl[k].ef);
            if (tbl[k].ev) begin
                chk("tbl_data", out_data, tbl[k].ed);
                chk("tbl_last", out_last, tbl[k].el);
            end
        end
        chk("tbl_ovf", overflow, 0);

        // ---- overflow plus set/clear collision
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr(W'(10 + i));
            if (i == 7) begin
                chk("ovf_full11", bank_full, 2'b11);
                chk("ovf_pre", overflow, 0);
            end
        end
        chk("ovf_set", overflow, 1);
        wea = 1'b1; din = W'(19); clr_ovf = 1'b1;
        cyc();
        wea = 1'b0; clr_ovf = 1'b0;
        chk("ovf_collision", overflow, 1);
        cyc();
        out_ready = 1'b1;
        wait_got("ovf_count", 8, 60);
        check_stream("ovf_stream", 10, 8);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_full00", bank_full, 0);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // ---- backpressure: 3 stalled cycles on every word
        do_reset();
        for (int i = 0; i < 4; i++) wr(W'(5 + i));
        for (int w = 0; w < 4; w++) begin
            wait_valid("bp_wait", 20);
            chk("bp_data", out_data, 5 + w);
            chk("bp_last", out_last, w == 3);
            for (int s = 0; s < 3; s++) begin
                cyc();
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_data", out_data, 5 + w);
                chk("bp_hold_last", out_last, w == 3);
            end
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
            chk("bp_drop_valid", out_valid, 0);
        end
        wait_got("bp_count", 4, 10);
        check_stream("bp_stream", 5, 4);

        // ---- concurrent fill/drain
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 12; i++) wr(W'(i));
        wait_got("cc_count", 12, 40);
        check_stream("cc_stream", 1, 12);
        chk("cc_ovf", overflow, 0);
        chk("cc_banks", drained.size(), 3);
        for (int b = 0; b < 3 && b < drained.size(); b++)
            chk("cc_bank_order", drained[b], (b % 2 == 0) ? 2'b01 : 2'b10);

        // ---- reset mid-stream on word 2
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) wr(W'(30 + i));
        for (int i = 0; i < 20 && got.size() < 1; i++) cyc();
        out_ready = 1'b0;
        chk("mid_first", got.size(), 1);
        wait_valid("mid_wait", 10);
        chk("mid_word2", out_data, 31);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_valid_drop", out_valid, 0);
        chk("mid_full", bank_full, 0);
        chk("mid_data", out_data, 0);
        cyc();
        cyc();
        reset = 1'b1;
        got.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) wr(W'(20 + i));
        wait_got("mid_count", 4, 30);
        check_stream("mid_stream", 20, 4);
        chk("mid_full_after", bank_full, 0);

        // ---- randomized run against the count model
        do_reset();
        n_in = 0; n_out = 0; m_ovf = 1'b0; prev_wea = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3400; i++) begin
            m_full = 2'b00;
            for (int b = n_out / D; b < n_in / D; b++) m_full[b % 2] = 1'b1;
            chk("rnd_full", bank_full, m_full);
            chk("rnd_ovf", overflow, m_ovf);
            if (out_valid) chk("rnd_valid_avail", (n_in / D) * D > n_out, 1);

            if (i < 3000) begin
                wea       = prev_wea ? 1'b0 : ($urandom_range(2) == 0);
                out_ready = ((i / 500) % 2 == 1) ? ($urandom_range(9) != 0)
                                                 : ($urandom_range(9) < 3);
                clr_ovf   = ($urandom_range(15) == 0);
            end else begin
                wea = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
            end
            din      = W'($urandom);
            prev_wea = wea;

            fb      = n_in / D - n_out / D;
            hs      = out_valid && out_ready;
            set_ovf = 1'b0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_word", 1, 0);
                end else begin
                    chk("rnd_data", out_data, exp_q[0]);
                    chk("rnd_last", out_last, (n_out % D) == D - 1);
                    void'(exp_q.pop_front());
                end
                n_out++;
            end
            if (wea) begin
                if (fb >= 2) set_ovf = 1'b1;
                else begin
                    exp_q.push_back(din);
                    n_in++;
                end
            end
            if (set_ovf)      m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            cyc();
        end
        chk("rnd_drained", n_out, (n_in / D) * D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
